serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_full_adder_bit.sv | 43 ++++
 rtl/serial_adder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// The state encoding is fixed so it matches the values seen on debug taps.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit-counter width; guards the degenerate $clog2(1) == 0 case.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// Full-adder cell for the serial adder: two half-adder cells and an OR gate.
// halfAdder keeps the port names of the existing library cell.
module halfAdder (
  input  logic a,
  input  logic b,
  output logic Sum,
  output logic Carry
);

  assign Sum   = a ^ b;
  assign Carry = a & b;

endmodule

module full_adder_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  halfAdder u_ha_ab (
    .a     (i_a),
    .b     (i_b),
    .Sum   (w_s1),
    .Carry (w_c1)
  );

  halfAdder u_ha_c (
    .a     (w_s1),
    .b     (i_c),
    .Sum   (o_s),
    .Carry (w_c2)
  );

  assign o_c = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first through one full-adder cell, one bit
// per clock, with valid/ready handshakes on operands and result.
//
// state | meaning
// IDLE  | start_ready high, waiting for operands
// SHIFT | one operand bit pair summed per cycle, WIDTH cycles
// DONE  | result_valid high until result_ready
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e r_state;
  state_e w_state_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Only WIDTH-1 bits are kept; the last sum bit goes straight to sum_out.
  logic [WIDTH-2:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout;
  logic             r_ovf;

  logic             w_fa_sum;
  logic             w_fa_carry;
  logic             w_accept;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_sum_next;

  full_adder_bit u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_carry),
    .o_s (w_fa_sum),
    .o_c (w_fa_carry)
  );

  assign w_accept   = (r_state == ST_IDLE) && start_valid;
  assign w_last_bit = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);
  assign w_sum_next = {w_fa_sum, r_sum_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start_valid)  w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_last_bit)   w_state_next = ST_DONE;
      ST_DONE:  if (result_ready) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_sum_sh  <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_sum_out <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= a_in;
      r_b_sh   <= b_in;
      r_sum_sh <= '0;
      r_carry  <= cin;
      r_cnt    <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_sum_sh <= w_sum_next[WIDTH-1:1];
      r_carry  <= w_fa_carry;
      if (w_last_bit) begin
        // r_carry here is the carry into the MSB; overflow compares it with the carry out.
        r_sum_out <= w_sum_next;
        r_cout    <= w_fa_carry;
        r_ovf     <= r_carry ^ w_fa_carry;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign start_ready  = (r_state == ST_IDLE) && !rst;
  assign result_valid = (r_state == ST_DONE);
  assign busy         = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign sum_out      = r_sum_out;
  assign cout         = r_cout;
  assign ovf          = r_ovf;

endmodule
